tri_iuq_cpl_ctrl: RTL and testbench

- Sequencer for the 2R/2W completion-buffer LUTRAM array (write, read-address and read-data ports all latched inside the array).
- Allocates entries as a ring buffer at dispatch (up to 2 per cycle) and writes payloads to consecutive addresses.
- Tracks per-entry valid/finish bits and reads out in-order completed entries (up to 2 per cycle).
- Sits between IU dispatch, the execution finish buses and the completion logic.

---
 rtl/tri_iuq_cpl_ctrl.sv | 161 ++++++++++++++++
 tb/tb_tri_iuq_cpl_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tri_iuq_cpl_ctrl.sv
// Completion-buffer sequencer: ring allocation, finish tracking and
// in-order dual readout of the 2R/2W completion LUTRAM.
module tri_iuq_cpl_ctrl #(
  parameter int AW = 6,
  parameter int DW = 64
) (
  input  logic          nclk,
  input  logic          reset_b,
  input  logic          disp_val0,
  input  logic          disp_val1,
  input  logic [DW-1:0] disp_data0,
  input  logic [DW-1:0] disp_data1,
  output logic          disp_rdy,
  output logic [AW-1:0] disp_itag0,
  output logic [AW-1:0] disp_itag1,
  input  logic          fin_val0,
  input  logic          fin_val1,
  input  logic [AW-1:0] fin_itag0,
  input  logic [AW-1:0] fin_itag1,
  input  logic          flush,
  output logic          arr_we0,
  output logic          arr_we1,
  output logic [AW-1:0] arr_wa0,
  output logic [AW-1:0] arr_wa1,
  output logic [DW-1:0] arr_di0,
  output logic [DW-1:0] arr_di1,
  output logic          arr_re0,
  output logic          arr_re1,
  output logic [AW-1:0] arr_ra0,
  output logic [AW-1:0] arr_ra1,
  input  logic [DW-1:0] arr_do0,
  input  logic [DW-1:0] arr_do1,
  output logic          cp_val0,
  output logic          cp_val1,
  output logic [AW-1:0] cp_itag0,
  output logic [AW-1:0] cp_itag1,
  output logic [DW-1:0] cp_data0,
  output logic [DW-1:0] cp_data1,
  output logic [AW:0]   free_cnt,
  output logic          empty
);

  localparam int ENTRIES = 2 ** AW;

  logic [AW-1:0]      head, tail;
  logic [AW-1:0]      head1, tail1;
  logic [ENTRIES-1:0] valid, fin;
  logic [ENTRIES-1:0] valid_n, fin_n;
  logic [AW:0]        occ, occ_n;
  logic               acc0, acc1, c0, c1;
  logic [1:0]         ndisp, nissue;
  logic [1:0]         s1_val;
  logic [AW-1:0]      s1_itag;

  assign head1 = head + AW'(1);
  assign tail1 = tail + AW'(1);

  assign free_cnt = (AW+1)'(ENTRIES) - occ;
  assign empty    = (occ == '0);
  assign disp_rdy = (free_cnt >= (AW+1)'(2));

  assign disp_itag0 = tail;
  assign disp_itag1 = tail1;

  // reset_b gates the write port so the array sees no writes while held
  assign acc0 = disp_val0 & disp_rdy & ~flush & reset_b;
  assign acc1 = acc0 & disp_val1;

  assign arr_we0 = acc0;
  assign arr_we1 = acc1;
  assign arr_wa0 = tail;
  assign arr_wa1 = tail1;
  assign arr_di0 = disp_data0;
  assign arr_di1 = disp_data1;

  assign c0 = valid[head] & fin[head] & ~flush;
  assign c1 = c0 & valid[head1] & fin[head1];

  assign arr_re0 = c0;
  assign arr_re1 = c1;
  assign arr_ra0 = head;
  assign arr_ra1 = head1;

  assign cp_data0 = arr_do0;
  assign cp_data1 = arr_do1;

  assign ndisp  = {1'b0, acc0} + {1'b0, acc1};
  assign nissue = {1'b0, c0} + {1'b0, c1};
  assign occ_n  = occ + (AW+1)'(ndisp) - (AW+1)'(nissue);

  always_comb begin
    valid_n = valid;
    fin_n   = fin;
    if (fin_val0 && valid[fin_itag0] && !flush)
      fin_n[fin_itag0] = 1'b1;
    if (fin_val1 && valid[fin_itag1] && !flush)
      fin_n[fin_itag1] = 1'b1;
    if (c0) begin
      valid_n[head] = 1'b0;
      fin_n[head]   = 1'b0;
    end
    if (c1) begin
      valid_n[head1] = 1'b0;
      fin_n[head1]   = 1'b0;
    end
    if (acc0) begin
      valid_n[tail] = 1'b1;
      fin_n[tail]   = 1'b0;
    end
    if (acc1) begin
      valid_n[tail1] = 1'b1;
      fin_n[tail1]   = 1'b0;
    end
  end

  always_ff @(posedge nclk or negedge reset_b) begin
    if (!reset_b) begin
      head  <= '0;
      tail  <= '0;
      valid <= '0;
      fin   <= '0;
      occ   <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      valid <= '0;
      fin   <= '0;
      occ   <= '0;
    end else begin
      head  <= head + AW'(nissue);
      tail  <= tail + AW'(ndisp);
      valid <= valid_n;
      fin   <= fin_n;
      occ   <= occ_n;
    end
  end

  // two-stage pipe lines tags up with the array's latched read data
  always_ff @(posedge nclk or negedge reset_b) begin
    if (!reset_b) begin
      s1_val   <= '0;
      s1_itag  <= '0;
      cp_val0  <= 1'b0;
      cp_val1  <= 1'b0;
      cp_itag0 <= '0;
      cp_itag1 <= '0;
    end else if (flush) begin
      s1_val  <= '0;
      cp_val0 <= 1'b0;
      cp_val1 <= 1'b0;
    end else begin
      s1_val   <= {c1, c0};
      s1_itag  <= head;
      cp_val0  <= s1_val[0];
      cp_val1  <= s1_val[1];
      cp_itag0 <= s1_itag;
      cp_itag1 <= s1_itag + AW'(1);
    end
  end

endmodule

// File: tb/tb_tri_iuq_cpl_ctrl.sv
// Directed bench for tri_iuq_cpl_ctrl with a latched 2R/2W array model.
module tb_tri_iuq_cpl_ctrl;

  logic        nclk = 1'b0;
  logic        reset_b;
  logic        disp_val0, disp_val1;
  logic [63:0] disp_data0, disp_data1;
  logic        disp_rdy;
  logic [5:0]  disp_itag0, disp_itag1;
  logic        fin_val0, fin_val1;
  logic [5:0]  fin_itag0, fin_itag1;
  logic        flush;
  logic        arr_we0, arr_we1;
  logic [5:0]  arr_wa0, arr_wa1;
  logic [63:0] arr_di0, arr_di1;
  logic        arr_re0, arr_re1;
  logic [5:0]  arr_ra0, arr_ra1;
  logic [63:0] arr_do0, arr_do1;
  logic        cp_val0, cp_val1;
  logic [5:0]  cp_itag0, cp_itag1;
  logic [63:0] cp_data0, cp_data1;
  logic [6:0]  free_cnt;
  logic        empty;

  int n_run  = 0;
  int n_fail = 0;

  always #5 nclk = ~nclk;

  tri_iuq_cpl_ctrl dut (
    .nclk(nclk), .reset_b(reset_b),
    .disp_val0(disp_val0), .disp_val1(disp_val1),
    .disp_data0(disp_data0), .disp_data1(disp_data1),
    .disp_rdy(disp_rdy),
    .disp_itag0(disp_itag0), .disp_itag1(disp_itag1),
    .fin_val0(fin_val0), .fin_val1(fin_val1),
    .fin_itag0(fin_itag0), .fin_itag1(fin_itag1),
    .flush(flush),
    .arr_we0(arr_we0), .arr_we1(arr_we1),
    .arr_wa0(arr_wa0), .arr_wa1(arr_wa1),
    .arr_di0(arr_di0), .arr_di1(arr_di1),
    .arr_re0(arr_re0), .arr_re1(arr_re1),
    .arr_ra0(arr_ra0), .arr_ra1(arr_ra1),
    .arr_do0(arr_do0), .arr_do1(arr_do1),
    .cp_val0(cp_val0), .cp_val1(cp_val1),
    .cp_itag0(cp_itag0), .cp_itag1(cp_itag1),
    .cp_data0(cp_data0), .cp_data1(cp_data1),
    .free_cnt(free_cnt), .empty(empty)
  );

  // array: writes, read address and read data all latched
  logic [63:0] mem [64];
  logic [5:0]  ra0_q, ra1_q;

  always @(posedge nclk) begin
    if (arr_we0) mem[arr_wa0] <= arr_di0;
    if (arr_we1) mem[arr_wa1] <= arr_di1;
    if (arr_re0) ra0_q <= arr_ra0;
    if (arr_re1) ra1_q <= arr_ra1;
    arr_do0 <= mem[ra0_q];
    arr_do1 <= mem[ra1_q];
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge nclk);
    #1;
  endtask

  task automatic idle();
    disp_val0 = 1'b0;
    disp_val1 = 1'b0;
    fin_val0  = 1'b0;
    fin_val1  = 1'b0;
    fin_itag0 = '0;
    fin_itag1 = '0;
    flush     = 1'b0;
  endtask

  task automatic disp2(input logic [63:0] a, input logic [63:0] b);
    disp_val0  = 1'b1;
    disp_val1  = 1'b1;
    disp_data0 = a;
    disp_data1 = b;
  endtask

  task automatic fin2(input logic [5:0] a, input logic [5:0] b);
    fin_val0  = 1'b1;
    fin_val1  = 1'b1;
    fin_itag0 = a;
    fin_itag1 = b;
  endtask

  initial begin
    reset_b    = 1'b0;
    disp_data0 = '0;
    disp_data1 = '0;
    idle();
    repeat (2) tick();
    reset_b = 1'b1;
    tick();

    // traffic, then reset asserted while completion is live
    disp2(64'hAA, 64'hBB);
    #1 chk("pre_we0", arr_we0, 1);
    tick(); idle();
    fin2(6'd0, 6'd1);
    tick(); idle();
    tick(); tick();
    chk("pre_cpval0", cp_val0, 1);
    disp_val0 = 1'b1;
    reset_b   = 1'b0;
    #1;
    chk("rst_cpval0", cp_val0, 0);
    chk("rst_cpval1", cp_val1, 0);
    chk("rst_we0", arr_we0, 0);
    tick(); idle();
    reset_b = 1'b1;
    tick();
    chk("rst_free", free_cnt, 64);
    chk("rst_empty", empty, 1);
    chk("rst_rdy", disp_rdy, 1);
    chk("rst_itag0", disp_itag0, 0);
    chk("rst_itag1", disp_itag1, 1);
    chk("rst_re0", arr_re0, 0);

    // pair dispatch and completion
    disp2(64'h11, 64'h22);
    #1;
    chk("p_we0", arr_we0, 1);
    chk("p_we1", arr_we1, 1);
    chk("p_wa0", arr_wa0, 0);
    chk("p_wa1", arr_wa1, 1);
    chk("p_di0", arr_di0, 64'h11);
    tick(); idle();
    chk("p_free62", free_cnt, 62);
    fin2(6'd0, 6'd1);
    tick(); idle();
    #1;
    chk("p_re0", arr_re0, 1);
    chk("p_re1", arr_re1, 1);
    chk("p_ra0", arr_ra0, 0);
    chk("p_ra1", arr_ra1, 1);
    tick(); tick();
    chk("p_cpval0", cp_val0, 1);
    chk("p_cpval1", cp_val1, 1);
    chk("p_cpitag0", cp_itag0, 0);
    chk("p_cpitag1", cp_itag1, 1);
    chk("p_cpdata0", cp_data0, 64'h11);
    chk("p_cpdata1", cp_data1, 64'h22);
    chk("p_free64", free_cnt, 64);
    tick();
    chk("p_cpval0_drop", cp_val0, 0);

    // out-of-order finish, plus a finish to an unallocated tag
    disp2(64'h33, 64'h44);
    tick(); idle();
    fin_val0  = 1'b1;
    fin_itag0 = 6'd3;
    tick(); idle();
    #1 chk("o_no_re", arr_re0, 0);
    fin2(6'd2, 6'd5);
    tick(); idle();
    #1;
    chk("o_re0", arr_re0, 1);
    chk("o_re1", arr_re1, 1);
    chk("o_ra0", arr_ra0, 2);
    chk("o_ra1", arr_ra1, 3);
    tick(); tick();
    chk("o_cpitag1", cp_itag1, 3);
    chk("o_cpdata0", cp_data0, 64'h33);
    chk("o_cpdata1", cp_data1, 64'h44);
    chk("o_empty", empty, 1);

    // lone slot-1 dispatch is ignored, then a single dispatch at tag 4
    disp_val1  = 1'b1;
    disp_data1 = 64'h99;
    #1 chk("s_we1_only", arr_we1, 0);
    tick(); idle();
    chk("s_free64", free_cnt, 64);
    disp_val0  = 1'b1;
    disp_data0 = 64'h55;
    #1 chk("s_we1_off", arr_we1, 0);
    tick(); idle();
    chk("s_free63", free_cnt, 63);
    fin_val0  = 1'b1;
    fin_itag0 = 6'd4;
    tick(); idle();
    #1;
    chk("s_re0", arr_re0, 1);
    chk("s_re1_tag5", arr_re1, 0);
    tick(); tick();
    chk("s_cpval0", cp_val0, 1);
    chk("s_cpval1", cp_val1, 0);
    chk("s_cpdata0", cp_data0, 64'h55);

    // fill from tail 5: pair 29 lands on the 63/0 wrap
    for (int k = 0; k < 31; k++) begin
      disp2(64'h100 + 64'(k), 64'h200 + 64'(k));
      #1;
      if (k == 29) begin
        chk("w_wa0", arr_wa0, 63);
        chk("w_wa1", arr_wa1, 0);
        chk("w_lsb", arr_wa0[0] ^ arr_wa1[0], 1);
      end
      tick();
    end
    idle();
    chk("f_free2", free_cnt, 2);
    chk("f_rdy2", disp_rdy, 1);
    disp2(64'h77, 64'h88);
    tick(); idle();
    chk("f_free0", free_cnt, 0);
    chk("f_rdy0", disp_rdy, 0);
    disp_val0 = 1'b1;
    #1 chk("f_we_full", arr_we0, 0);
    tick(); idle();
    chk("f_free0b", free_cnt, 0);

    // flush one cycle after the read is issued
    fin2(6'd5, 6'd6);
    tick(); idle();
    #1;
    chk("x_re0", arr_re0, 1);
    chk("x_ra0", arr_ra0, 5);
    tick();
    chk("x_free2", free_cnt, 2);
    flush     = 1'b1;
    disp2(64'hEE, 64'hFF);
    #1 chk("x_we_flush", arr_we0, 0);
    tick(); idle();
    chk("x_cpval0_a", cp_val0, 0);
    chk("x_free64", free_cnt, 64);
    chk("x_itag0", disp_itag0, 0);
    tick();
    chk("x_cpval0_b", cp_val0, 0);
    chk("x_cpval1_b", cp_val1, 0);

    // simultaneous dual dispatch and dual issue at occupancy 10
    for (int k = 0; k < 5; k++) begin
      disp2(64'h300 + 64'(k), 64'h400 + 64'(k));
      tick();
    end
    idle();
    chk("b_free54", free_cnt, 54);
    fin2(6'd0, 6'd1);
    tick(); idle();
    disp2(64'h500, 64'h501);
    #1;
    chk("b_re1", arr_re1, 1);
    chk("b_we1", arr_we1, 1);
    chk("b_wa0", arr_wa0, 10);
    tick(); idle();
    chk("b_free54b", free_cnt, 54);
    tick();
    chk("b_cpval1", cp_val1, 1);
    chk("b_cpdata1", cp_data1, 64'h400);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
